// File: rtl/keylock_pkg.sv
// Shared types and constants for the keylock controller.
// Holds the FSM state type, the clear-key encoding, the digit width and a
// helper used to size the shared timer.
package keylock_pkg;

    localparam int unsigned KL_DIGIT_W = 4;

    localparam logic [KL_DIGIT_W-1:0] KEY_CLEAR     = 4'hA;
    localparam logic [KL_DIGIT_W-1:0] KEY_MAX_DIGIT = 4'h9;

    typedef enum logic [1:0] {
        ENTRY    = 2'd0,
        UNLOCKED = 2'd1,
        LOCKOUT  = 2'd2
    } kl_state_t;

    // Largest of three cycle counts; sizes the single shared timer.
    function automatic int unsigned kl_max3(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/keylock_timer.sv
// Loadable down-counter shared by all keylock states.
// Ports:
//   clk, reset_n : clock, async active-low reset (count resets to 0)
//   load         : load load_val this cycle (has priority over counting)
//   load_val     : value to load
//   expired      : count is zero (counter holds at zero)
module keylock_timer #(
    parameter int unsigned CNT_W = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: load wins, otherwise decrement until zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/keylock_ctrl.sv
// Keypad-entry controller: compares keyed digits against a stored code,
// counts consecutive failures, enforces a timed lockout and relocks after a
// fixed unlock window.
// Ports:
//   clk, reset_n            : clock, async active-low reset
//   key/key_valid/key_ready : digit handshake (4'hA clears the entry)
//   relock                  : force relock while unlocked
//   prog_valid/prog_code    : code programming (KEYLOCK_CODE_PROG_EN only)
//   locked, lockout         : state indications
//   unlock_pulse/fail_pulse : one-cycle event pulses
//   digit_count, fail_count : progress of current attempt / failure count
// Configuration: define KEYLOCK_CODE_PROG_EN to add the programming port;
// otherwise the code is the constant DEFAULT_CODE.
module keylock_ctrl
    import keylock_pkg::*;
#(
    parameter int unsigned                         CODE_LEN       = 6,
    parameter logic [KL_DIGIT_W*CODE_LEN-1:0]      DEFAULT_CODE   = 24'h335256,
    parameter int unsigned                         MAX_FAILS      = 3,
    parameter int unsigned                         LOCKOUT_CYCLES = 1000,
    parameter int unsigned                         UNLOCK_CYCLES  = 500,
    parameter int unsigned                         ENTRY_TIMEOUT  = 200
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [KL_DIGIT_W-1:0]                key,
    input  logic                                 key_valid,
    output logic                                 key_ready,
    input  logic                                 relock,
`ifdef KEYLOCK_CODE_PROG_EN
    input  logic                                 prog_valid,
    input  logic [KL_DIGIT_W*CODE_LEN-1:0]       prog_code,
`endif
    output logic                                 locked,
    output logic                                 lockout,
    output logic                                 unlock_pulse,
    output logic                                 fail_pulse,
    output logic [2:0]                           digit_count,
    output logic [$clog2(MAX_FAILS+1)-1:0]       fail_count
);

    localparam int unsigned CODE_W  = KL_DIGIT_W * CODE_LEN;
    localparam int unsigned FC_W    = $clog2(MAX_FAILS + 1);
    localparam int unsigned TMR_MAX = kl_max3(LOCKOUT_CYCLES, UNLOCK_CYCLES, ENTRY_TIMEOUT);
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    kl_state_t         state_q, state_d;
    logic [2:0]        digit_q, digit_d;
    logic              mism_q, mism_d;
    logic [FC_W-1:0]   fail_q, fail_d;
    logic              locked_q, lockout_q, ready_q;
    logic              unlock_q, unlock_d;
    logic              failp_q, failp_d;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_expired;
    logic [CODE_W-1:0] code;

    logic                  key_acc;
    logic [KL_DIGIT_W-1:0] exp_digit;
    logic                  key_mm;
    logic [FC_W-1:0]       fail_inc;

`ifdef KEYLOCK_CODE_PROG_EN
    logic [CODE_W-1:0] code_q, code_d;
    assign code = code_q;
`else
    assign code = DEFAULT_CODE;
`endif

    keylock_timer #(
        .CNT_W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    // First digit lives in the most-significant nibble.
    assign exp_digit = code[KL_DIGIT_W*(CODE_LEN-1-int'(digit_q)) +: KL_DIGIT_W];
    assign key_acc   = key_valid && ready_q;
    assign key_mm    = (key > KEY_MAX_DIGIT) || (key != exp_digit);
    assign fail_inc  = fail_q + FC_W'(1);

    // Next-state and event logic.
    always_comb begin
        state_d  = state_q;
        digit_d  = digit_q;
        mism_d   = mism_q;
        fail_d   = fail_q;
        unlock_d = 1'b0;
        failp_d  = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = TMR_W'(ENTRY_TIMEOUT - 1);
`ifdef KEYLOCK_CODE_PROG_EN
        code_d   = code_q;
`endif
        case (state_q)
            ENTRY: begin
                if (key_acc) begin
                    // Any accepted key restarts the inter-digit timeout.
                    tmr_load = 1'b1;
                    if (key == KEY_CLEAR) begin
                        digit_d = '0;
                        mism_d  = 1'b0;
                    end else if (digit_q == 3'(CODE_LEN - 1)) begin
                        digit_d = '0;
                        mism_d  = 1'b0;
                        if (!(mism_q || key_mm)) begin
                            state_d  = UNLOCKED;
                            fail_d   = '0;
                            unlock_d = 1'b1;
                            tmr_val  = TMR_W'(UNLOCK_CYCLES - 1);
                        end else begin
                            failp_d = 1'b1;
                            fail_d  = fail_inc;
                            if (fail_inc == FC_W'(MAX_FAILS)) begin
                                state_d = LOCKOUT;
                                tmr_val = TMR_W'(LOCKOUT_CYCLES - 1);
                            end
                        end
                    end else begin
                        digit_d = digit_q + 3'd1;
                        mism_d  = mism_q || key_mm;
                    end
                end else if (tmr_expired && (digit_q != '0)) begin
                    // Abandoned partial entry: discard without a failure.
                    digit_d = '0;
                    mism_d  = 1'b0;
                end
            end
            UNLOCKED: begin
`ifdef KEYLOCK_CODE_PROG_EN
                if (prog_valid) begin
                    code_d = prog_code;
                end
                if (relock || prog_valid || tmr_expired) begin
`else
                if (relock || tmr_expired) begin
`endif
                    state_d  = ENTRY;
                    digit_d  = '0;
                    mism_d   = 1'b0;
                    tmr_load = 1'b1;
                end
            end
            LOCKOUT: begin
                if (tmr_expired) begin
                    state_d  = ENTRY;
                    fail_d   = '0;
                    tmr_load = 1'b1;
                end
            end
            default: begin
                state_d = ENTRY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ENTRY;
            digit_q   <= '0;
            mism_q    <= 1'b0;
            fail_q    <= '0;
            locked_q  <= 1'b1;
            lockout_q <= 1'b0;
            ready_q   <= 1'b1;
            unlock_q  <= 1'b0;
            failp_q   <= 1'b0;
`ifdef KEYLOCK_CODE_PROG_EN
            code_q    <= DEFAULT_CODE;
`endif
        end else begin
            state_q   <= state_d;
            digit_q   <= digit_d;
            mism_q    <= mism_d;
            fail_q    <= fail_d;
            locked_q  <= (state_d != UNLOCKED);
            lockout_q <= (state_d == LOCKOUT);
            ready_q   <= (state_d == ENTRY);
            unlock_q  <= unlock_d;
            failp_q   <= failp_d;
`ifdef KEYLOCK_CODE_PROG_EN
            code_q    <= code_d;
`endif
        end
    end

    assign key_ready    = ready_q;
    assign locked       = locked_q;
    assign lockout      = lockout_q;
    assign unlock_pulse = unlock_q;
    assign fail_pulse   = failp_q;
    assign digit_count  = digit_q;
    assign fail_count   = fail_q;

endmodule
